// File: rtl/dmem_responder.sv
// Data-memory responder: single outstanding request, byte-masked writes, fixed-latency response.
// Optional DMEM_ACCESS_ERR_EN adds dmem_err_o with out-of-range / misaligned checks.
module dmem_responder #(
  parameter int unsigned DEPTH   = 1024,
  parameter int unsigned LATENCY = 1,
  localparam int unsigned ADDRW  = 32,
  localparam int unsigned XLEN   = 32,
  localparam int unsigned MASKW  = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             dmem_valid_i,
  output logic             dmem_ready_o,
  input  logic [ADDRW-1:0] dmem_addr_i,
  input  logic [MASKW-1:0] dmem_mask_i,
  input  logic [XLEN-1:0]  dmem_wdata_i,
  input  logic             dmem_we_i,
  output logic             dmem_rsp_valid_o,
  output logic [XLEN-1:0]  dmem_rdata_o
`ifdef DMEM_ACCESS_ERR_EN
  ,
  output logic             dmem_err_o
`endif
);

  localparam int unsigned IW       = $clog2(DEPTH);
  localparam int unsigned CW       = 3;
  localparam int unsigned CNT_INIT = (LATENCY > 1) ? LATENCY - 2 : 0;

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_e;

  state_e            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [XLEN-1:0]   cap_q, cap_d;
  logic              load_q, load_d;
  logic              err_q, err_d;
  logic              ready_q, ready_d;
  logic              rsp_q, rsp_d;
  logic [XLEN-1:0]   rdata_q, rdata_d;
  logic              erro_q, erro_d;

  logic              accept_c;
  logic              err_c;
  logic [IW-1:0]     idx_c;
  logic [XLEN-1:0]   rd_word_c;
  logic [XLEN-1:0]   mem [DEPTH];

  assign idx_c     = dmem_addr_i[IW+1:2];
  assign rd_word_c = mem[idx_c];
  assign accept_c  = dmem_valid_i && ready_q;

`ifdef DMEM_ACCESS_ERR_EN
  assign err_c = (|dmem_addr_i[ADDRW-1:IW+2]) | (|dmem_addr_i[1:0]);
`else
  // Upper address bits wrap; alignment bits are zero by protocol.
  logic unused_addr_c;
  assign unused_addr_c = ^{dmem_addr_i[ADDRW-1:IW+2], dmem_addr_i[1:0]};
  assign err_c = 1'b0;
`endif

  // Storage: no reset, lane-masked write committed at the accept edge.
  always_ff @(posedge clk_i) begin
    if (accept_c && dmem_we_i && !err_c) begin
      for (int b = 0; b < int'(MASKW); b++) begin
        if (dmem_mask_i[b]) mem[idx_c][8*b +: 8] <= dmem_wdata_i[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      cap_q   <= '0;
      load_q  <= 1'b0;
      err_q   <= 1'b0;
      ready_q <= 1'b1;
      rsp_q   <= 1'b0;
      rdata_q <= '0;
      erro_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cap_q   <= cap_d;
      load_q  <= load_d;
      err_q   <= err_d;
      ready_q <= ready_d;
      rsp_q   <= rsp_d;
      rdata_q <= rdata_d;
      erro_q  <= erro_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cap_d   = cap_q;
    load_d  = load_q;
    err_d   = err_q;

    case (state_q)
      ST_IDLE: state_d = ST_IDLE;
      ST_WAIT: begin
        if (cnt_q == '0) state_d = ST_RESP;
        else             cnt_d   = cnt_q - CW'(1);
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    // Accept is only possible in IDLE or RESP (ready high) and overrides the above.
    if (accept_c) begin
      cap_d   = err_c ? '0 : rd_word_c;
      load_d  = !dmem_we_i;
      err_d   = err_c;
      cnt_d   = CW'(CNT_INIT);
      state_d = (LATENCY > 1) ? ST_WAIT : ST_RESP;
    end

    ready_d = (state_d != ST_WAIT);
    rsp_d   = (state_d == ST_RESP);
    rdata_d = (rsp_d && load_d) ? cap_d : '0;
    erro_d  = rsp_d && err_d;
  end

  assign dmem_ready_o     = ready_q;
  assign dmem_rsp_valid_o = rsp_q;
  assign dmem_rdata_o     = rdata_q;
`ifdef DMEM_ACCESS_ERR_EN
  assign dmem_err_o       = erro_q;
`else
  logic unused_err_c;
  assign unused_err_c = erro_q;
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: four instances with LATENCY 1..4, table-driven requests plus
// hand sequences for back-to-back and reset-mid-operation.
module tb_dmem_responder;

  logic              clk = 1'b0;
  logic              rst_ni = 1'b0;
  logic [3:0]        valid = '0;
  logic [3:0]        we = '0;
  logic [3:0][31:0]  addr = '0;
  logic [3:0][3:0]   mask = '0;
  logic [3:0][31:0]  wdata = '0;
  logic [3:0]        ready;
  logic [3:0]        rsp;
  logic [3:0][31:0]  rdata;
  logic [3:0]        err;

  int n_cmp = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    dmem_responder #(.DEPTH(1024), .LATENCY(g + 1)) u_dut (
      .clk_i            (clk),
      .rst_ni           (rst_ni),
      .dmem_valid_i     (valid[g]),
      .dmem_ready_o     (ready[g]),
      .dmem_addr_i      (addr[g]),
      .dmem_mask_i      (mask[g]),
      .dmem_wdata_i     (wdata[g]),
      .dmem_we_i        (we[g]),
      .dmem_rsp_valid_o (rsp[g]),
      .dmem_rdata_o     (rdata[g])
`ifdef DMEM_ACCESS_ERR_EN
      ,
      .dmem_err_o       (err[g])
`endif
    );
`ifndef DMEM_ACCESS_ERR_EN
    assign err[g] = 1'b0;
`endif
  end

  typedef struct {
    int          inst;
    bit          we;
    logic [31:0] addr;
    logic [3:0]  mask;
    logic [31:0] wdata;
    logic [31:0] exp;
    bit          exp_err;
  } vec_t;

  vec_t tbl[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input int inst, input bit w, input logic [31:0] a,
                              input logic [3:0] m, input logic [31:0] d,
                              input logic [31:0] e, input bit ee);
    vec_t v;
    v.inst = inst; v.we = w; v.addr = a; v.mask = m; v.wdata = d; v.exp = e; v.exp_err = ee;
    return v;
  endfunction

  task automatic wait_ready(input int i);
    int n = 0;
    @(negedge clk);
    while (!ready[i] && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!ready[i]) check("ready_timeout", 32'(ready[i]), 32'd1);
  endtask

  // One request, then per-cycle checks until the response has come and gone.
  task automatic do_req(input vec_t v);
    int i = v.inst;
    int lat = v.inst + 1;
    wait_ready(i);
    valid[i] = 1'b1; we[i] = v.we; addr[i] = v.addr; mask[i] = v.mask; wdata[i] = v.wdata;
    @(negedge clk);
    valid[i] = 1'b0;
    for (int k = 1; k <= lat; k++) begin
      if (k < lat) begin
        check("wait_rsp", 32'(rsp[i]), 32'd0);
        check("wait_ready", 32'(ready[i]), 32'd0);
        check("wait_rdata", rdata[i], 32'd0);
        @(negedge clk);
      end else begin
        check("rsp_valid", 32'(rsp[i]), 32'd1);
        check("rsp_ready", 32'(ready[i]), 32'd1);
        check("rsp_rdata", rdata[i], v.we ? 32'd0 : v.exp);
`ifdef DMEM_ACCESS_ERR_EN
        check("rsp_err", 32'(err[i]), 32'(v.exp_err));
`endif
      end
    end
    @(negedge clk);
    check("post_rsp", 32'(rsp[i]), 32'd0);
    check("post_rdata", rdata[i], 32'd0);
  endtask

  initial begin
    int acc_cyc[4];
    int nacc, nrsp;
    bit adv, seen;
    logic [31:0] bb_data[4];

    // LATENCY=1 word and partial-lane writes
    tbl.push_back(mk(0, 1, 32'h40, 4'hF, 32'hDEADBEEF, 32'h0, 0));
    tbl.push_back(mk(0, 0, 32'h40, 4'hF, 32'h0, 32'hDEADBEEF, 0));
    tbl.push_back(mk(0, 1, 32'h44, 4'hF, 32'hAABBCCDD, 32'h0, 0));
    tbl.push_back(mk(0, 1, 32'h44, 4'b1001, 32'h11000022, 32'h0, 0));
    tbl.push_back(mk(0, 0, 32'h44, 4'h0, 32'h0, 32'h11BBCC22, 0));
    // LATENCY=3 byte write and empty-mask write
    tbl.push_back(mk(2, 1, 32'h80, 4'hF, 32'h11223344, 32'h0, 0));
    tbl.push_back(mk(2, 1, 32'h80, 4'b0100, 32'h00AA0000, 32'h0, 0));
    tbl.push_back(mk(2, 0, 32'h80, 4'hF, 32'h0, 32'h11AA3344, 0));
    tbl.push_back(mk(2, 1, 32'h80, 4'h0, 32'hFFFFFFFF, 32'h0, 0));
    tbl.push_back(mk(2, 0, 32'h80, 4'hF, 32'h0, 32'h11AA3344, 0));
    // LATENCY=2 preload for back-to-back
    for (int k = 0; k < 4; k++) begin
      bb_data[k] = 32'hA0A0_0000 + 32'(k * 17);
      tbl.push_back(mk(1, 1, 32'(4 * k), 4'hF, bb_data[k], 32'h0, 0));
    end
    // LATENCY=4 store that must survive a later reset
    tbl.push_back(mk(3, 1, 32'h100, 4'hF, 32'hCAFEF00D, 32'h0, 0));
`ifdef DMEM_ACCESS_ERR_EN
    tbl.push_back(mk(0, 1, 32'h0, 4'hF, 32'h12345678, 32'h0, 0));
    tbl.push_back(mk(0, 1, 32'h1000, 4'hF, 32'hFFFFFFFF, 32'h0, 1));
    tbl.push_back(mk(0, 0, 32'h0, 4'hF, 32'h0, 32'h12345678, 0));
    tbl.push_back(mk(0, 0, 32'h1000, 4'hF, 32'h0, 32'h0, 1));
    tbl.push_back(mk(0, 0, 32'h42, 4'hF, 32'h0, 32'h0, 1));
`else
    tbl.push_back(mk(0, 1, 32'h0, 4'hF, 32'h12345678, 32'h0, 0));
    tbl.push_back(mk(0, 1, 32'h1000, 4'hF, 32'hFFFFFFFF, 32'h0, 0));
    tbl.push_back(mk(0, 0, 32'h0, 4'hF, 32'h0, 32'hFFFFFFFF, 0));
`endif

    // Reset held for 3 cycles, then idle
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("rst_ready", 32'(ready), 32'hF);
      check("rst_rsp", 32'(rsp), 32'h0);
    end
    rst_ni = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("idle_ready", 32'(ready), 32'hF);
      check("idle_rsp", 32'(rsp), 32'h0);
      check("idle_rdata", rdata[0] | rdata[1] | rdata[2] | rdata[3], 32'h0);
      check("idle_err", 32'(err), 32'h0);
    end

    foreach (tbl[n]) do_req(tbl[n]);

    // Back-to-back loads on LATENCY=2 with valid held high
    wait_ready(1);
    valid[1] = 1'b1; we[1] = 1'b0; addr[1] = 32'h0; mask[1] = 4'hF;
    nacc = 0; nrsp = 0;
    for (int cyc = 0; cyc < 16; cyc++) begin
      adv = 1'b0;
      if (valid[1] && ready[1]) begin
        if (nacc < 4) acc_cyc[nacc] = cyc;
        nacc++;
        adv = 1'b1;
      end
      @(negedge clk);
      if (adv) begin
        if (nacc >= 4) valid[1] = 1'b0;
        else addr[1] = 32'(4 * nacc);
      end
      if (rsp[1]) begin
        if (nrsp < 4) begin
          check("b2b_rdata", rdata[1], bb_data[nrsp]);
          check("b2b_latency", 32'(cyc + 1 - acc_cyc[nrsp]), 32'd2);
        end
        nrsp++;
      end
    end
    valid[1] = 1'b0;
    check("b2b_accepts", 32'(nacc), 32'd4);
    check("b2b_responses", 32'(nrsp), 32'd4);
    for (int k = 1; k < 4; k++) check("b2b_spacing", 32'(acc_cyc[k] - acc_cyc[k-1]), 32'd2);

    // Reset two cycles into a LATENCY=4 load: its response must never appear
    wait_ready(3);
    valid[3] = 1'b1; we[3] = 1'b0; addr[3] = 32'h100; mask[3] = 4'hF;
    @(negedge clk);
    valid[3] = 1'b0;
    seen = rsp[3];
    @(negedge clk);
    seen |= rsp[3];
    rst_ni = 1'b0;
    #1;
    check("midrst_ready", 32'(ready[3]), 32'd1);
    check("midrst_rdata", rdata[3], 32'd0);
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (c == 1) rst_ni = 1'b1;
      seen |= rsp[3];
    end
    check("midrst_no_rsp", 32'(seen), 32'd0);
    do_req(mk(3, 0, 32'h100, 4'hF, 32'h0, 32'hCAFEF00D, 0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
